// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, colour palette and playfield bounds.
// The pixel/game logic imports this package, so the raster geometry is defined in one place.
package vga_timing_pkg;

  // Default raster timing, in pixel clocks and lines.
  localparam int CLK_DIV     = 4;
  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_ACT_START = 144;
  localparam int H_ACT_END   = 784;
  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 35;
  localparam int V_ACT_END   = 515;
  localparam int TICK_FRAMES = 1;

  // 12-bit {R,G,B} palette used by the pixel logic.
  localparam logic [11:0] BLACK        = 12'h000;
  localparam logic [11:0] WHITE        = 12'hFFF;
  localparam logic [11:0] RED          = 12'hF00;
  localparam logic [11:0] PINK         = 12'hF6B;
  localparam logic [11:0] BLUE         = 12'h00F;
  localparam logic [11:0] PURPLE       = 12'h80F;
  localparam logic [11:0] BRIGHT_GREEN = 12'h0F0;

  // Playfield bounds in raster coordinates, inside the visible window.
  localparam logic [9:0] LEFT_WALL_X  = 10'd160;
  localparam logic [9:0] RIGHT_WALL_X = 10'd767;
  localparam logic [9:0] CEILING_Y    = 10'd51;
  localparam logic [9:0] FLOOR_Y      = 10'd498;

  // Half-open interval test: lo <= v < hi.
  function automatic logic in_span(input logic [9:0] v,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel-rate strobe generator: divides clk by CLK_DIV and raises pix_en
// for one clk on the last phase of each pixel period.
module pix_en_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // Free-running divider phase, wrapping at CLK_DIV-1.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                      div <= div + 1'b1;
  end

  // Decoded from the register, so the strobe is glitch-free and lands on the final phase.
  assign pix_en = (div == DIV_LAST);

endmodule

// File: rtl/vga_display_timer.sv
// VGA raster timer: pixel strobe, hCount/vCount raster bus, active-region flag,
// registered sync/colour pin drivers and frame/game update ticks.
module vga_display_timer #(
  parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
  parameter int H_ACT_END   = vga_timing_pkg::H_ACT_END,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
  parameter int V_ACT_END   = vga_timing_pkg::V_ACT_END,
  parameter int TICK_FRAMES = vga_timing_pkg::TICK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        frame_tick,
  output logic        game_tick,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W   = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W   = 10'(V_SYNC);
  localparam logic [9:0] H_A_START  = 10'(H_ACT_START);
  localparam logic [9:0] H_A_END    = 10'(H_ACT_END);
  localparam logic [9:0] V_A_START  = 10'(V_ACT_START);
  localparam logic [9:0] V_A_END    = 10'(V_ACT_END);
  localparam logic [9:0] V_PRE_BLNK = 10'(V_ACT_END - 1);
  localparam logic [7:0] TICK_LAST  = 8'(TICK_FRAMES - 1);

  logic        line_end;
  logic        frame_edge;
  logic [7:0]  frame_cnt;
  logic [11:0] rgb_q;

  pix_en_gen #(.CLK_DIV(CLK_DIV)) u_pix_en_gen (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  assign line_end = (hCount == H_LAST);
  // True on the pixel edge that moves the raster onto (0, V_ACT_END): start of vertical blanking.
  assign frame_edge = pix_en && line_end && (vCount == V_PRE_BLNK);

  // Raster counters advance once per pixel; the line wrap carries into vCount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  assign bright = in_span(hCount, H_A_START, H_A_END) &&
                  in_span(vCount, V_A_START, V_A_END);

  // Pin stage: sync and colour for the same raster position are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      rgb_q  <= BLACK;
    end else if (pix_en) begin
      vga_hs <= ~(hCount < H_SYNC_W);
      vga_vs <= ~(vCount < V_SYNC_W);
      rgb_q  <= bright ? rgb_in : BLACK;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

  // One-clk frame tick at blanking start, and a game tick on every TICK_FRAMES-th frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
      game_tick  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_tick <= frame_edge;
      game_tick  <= 1'b0;
      if (frame_edge) begin
        if (frame_cnt == TICK_LAST) begin
          frame_cnt <= '0;
          game_tick <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule
